// File: rtl/keycode_pkg.sv
// keycode_pkg
// Shared definitions for the keypad code-entry path: default code geometry
// (also used by the alarm code comparator) and the entry FSM state encoding.
package keycode_pkg;

  // Default code geometry shared between the entry buffer and the comparator.
  localparam int KEYCODE_NUM_DIGITS = 4;
  localparam int KEYCODE_DIGIT_W    = 4;

  // Entry FSM state, 2-bit encoding kept as plain constants so legacy
  // blocks that compare raw state bits keep working.
  typedef logic [1:0] keycode_state_t;

  localparam keycode_state_t ST_IDLE  = 2'd0;
  localparam keycode_state_t ST_ENTRY = 2'd1;
  localparam keycode_state_t ST_FULL  = 2'd2;

  // The state is fully determined by how many digits are held, so the FSM
  // derives its next state from the next digit count rather than tracking
  // transitions separately.
  function automatic keycode_state_t state_for_count(input int count,
                                                      input int num_digits);
    keycode_state_t st;
    if (count == 0) begin
      st = ST_IDLE;
    end else if (count >= num_digits) begin
      st = ST_FULL;
    end else begin
      st = ST_ENTRY;
    end
    return st;
  endfunction

endpackage

// File: rtl/keycode_entry_idle_timer.sv
// keycode_entry_idle_timer
// Inactivity counter for a partially entered keycode.
//
// Ports:
//   clock   in   system clock, rising edge
//   resetn  in   synchronous, active-low reset
//   clear   in   restart the count from zero (has priority over enable)
//   enable  in   count one cycle of inactivity
//   expire  out  high for the cycle in which the count reaches TIMEOUT_CYC-1
//                while enabled and not cleared
module keycode_entry_idle_timer
  import keycode_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] idle_cnt;

  // Expiry is suppressed when the owner is restarting the count this cycle,
  // so user activity on the final cycle always wins over the timeout.
  assign expire = enable && !clear && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      idle_cnt <= '0;
    end else if (enable) begin
      if (expire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keycode_entry.sv
// keycode_entry
// Keypad code-entry buffer for the home alarm. Collects NUM_DIGITS digits of
// DIGIT_W bits from single-cycle write strobes, supports backspace and clear,
// and presents the finished code to the comparator with a valid/ack handshake.
//
// Ports:
//   clock         in   system clock, rising edge
//   resetn        in   synchronous, active-low reset
//   write         in   strobe: digit is entered this cycle
//   digit         in   digit value sampled with write
//   backspace     in   strobe: remove the most recently entered digit
//   clear         in   strobe: discard the whole entry
//   code_ack      in   comparator has consumed out_keycode
//   out_keycode   out  packed code, k-th entered digit at [k*DIGIT_W +: DIGIT_W]
//   digit_count   out  number of digits currently held
//   code_valid    out  complete code presented (level, held until code_ack)
//   entry_active  out  a partial code (1..NUM_DIGITS-1 digits) is held
//   timeout       out  one-cycle pulse when a partial entry is abandoned
//
// Build option: define KEYCODE_TIMEOUT_EN to abandon a partial entry after
// TIMEOUT_CYC idle cycles. Without it, timeout is constant 0.
module keycode_entry
  import keycode_pkg::*;
#(
  parameter int NUM_DIGITS  = KEYCODE_NUM_DIGITS,
  parameter int DIGIT_W     = KEYCODE_DIGIT_W,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          write,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          backspace,
  input  logic                          clear,
  input  logic                          code_ack,
  output logic [NUM_DIGITS*DIGIT_W-1:0] out_keycode,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                          code_valid,
  output logic                          entry_active,
  output logic                          timeout
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  keycode_state_t                         state;
  keycode_state_t                         state_next;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     slots;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     slots_next;
  logic [CNT_W-1:0]                       count;
  logic [CNT_W-1:0]                       count_next;

`ifdef KEYCODE_TIMEOUT_EN
  logic accepted;
  logic idle_expire;
  logic timeout_next;
`endif

  // Next-value logic. Exactly one action per cycle, in priority order:
  // clear, ack of a presented code, backspace, write, then (optionally) the
  // inactivity timeout. Slots above the count are always kept at zero, so
  // backspace zeroes the slot it releases and every flush zeroes everything.
  always_comb begin
    slots_next = slots;
    count_next = count;
`ifdef KEYCODE_TIMEOUT_EN
    accepted     = 1'b0;
    timeout_next = 1'b0;
`endif
    if (clear) begin
      slots_next = '0;
      count_next = '0;
`ifdef KEYCODE_TIMEOUT_EN
      accepted = 1'b1;
`endif
    end else if (state == ST_FULL && code_ack) begin
      slots_next = '0;
      count_next = '0;
`ifdef KEYCODE_TIMEOUT_EN
      accepted = 1'b1;
`endif
    end else if (backspace && count != '0) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (CNT_W'(k) == count - CNT_W'(1)) begin
          slots_next[k] = '0;
        end
      end
      count_next = count - CNT_W'(1);
`ifdef KEYCODE_TIMEOUT_EN
      accepted = 1'b1;
`endif
    end else if (write && state != ST_FULL) begin
      // A full buffer ignores further digits instead of wrapping to slot 0.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (CNT_W'(k) == count) begin
          slots_next[k] = digit;
        end
      end
      count_next = count + CNT_W'(1);
`ifdef KEYCODE_TIMEOUT_EN
      accepted = 1'b1;
`endif
`ifdef KEYCODE_TIMEOUT_EN
    end else if (idle_expire) begin
      slots_next   = '0;
      count_next   = '0;
      timeout_next = 1'b1;
`endif
    end
    state_next = state_for_count(int'(count_next), NUM_DIGITS);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
      slots <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      slots <= slots_next;
      count <= count_next;
    end
  end

`ifdef KEYCODE_TIMEOUT_EN
  // The timer only runs in ENTRY. It is held at zero in IDLE and FULL, so a
  // complete code waiting for the comparator can never time out, and every
  // accepted action restarts the idle interval.
  keycode_entry_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clock (clock),
    .resetn(resetn),
    .clear (accepted || (state != ST_ENTRY)),
    .enable(state == ST_ENTRY),
    .expire(idle_expire)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // All outputs come straight from registers or a decode of the registered
  // state, so nothing combinational reaches the comparator from the keypad.
  assign out_keycode  = slots;
  assign digit_count  = count;
  assign code_valid   = (state == ST_FULL);
  assign entry_active = (state == ST_ENTRY);

endmodule

// File: tb/tb_keycode_entry.sv
// tb_keycode_entry
// Directed self-checking bench for keycode_entry: a default 4x4 instance and a
// 6-digit, 3-bit instance share clock and reset. Inputs change on the falling
// edge and outputs are sampled on the following falling edge.
// With KEYCODE_TIMEOUT_EN defined, the timeout path is exercised with
// TIMEOUT_CYC=8; otherwise timeout is expected to stay 0.
module tb_keycode_entry;

  logic        clock;
  logic        resetn;

  logic        write;
  logic [3:0]  digit;
  logic        backspace;
  logic        clear;
  logic        code_ack;
  logic [15:0] out_keycode;
  logic [2:0]  digit_count;
  logic        code_valid;
  logic        entry_active;
  logic        timeout;

  logic        write6;
  logic [2:0]  digit6;
  logic        backspace6;
  logic        clear6;
  logic        code_ack6;
  logic [17:0] out_keycode6;
  logic [2:0]  digit_count6;
  logic        code_valid6;
  logic        entry_active6;
  logic        timeout6;

  int checks;
  int passed;

  keycode_entry #(
    .NUM_DIGITS (4),
    .DIGIT_W    (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .write       (write),
    .digit       (digit),
    .backspace   (backspace),
    .clear       (clear),
    .code_ack    (code_ack),
    .out_keycode (out_keycode),
    .digit_count (digit_count),
    .code_valid  (code_valid),
    .entry_active(entry_active),
    .timeout     (timeout)
  );

  keycode_entry #(
    .NUM_DIGITS (6),
    .DIGIT_W    (3),
    .TIMEOUT_CYC(8)
  ) dut6 (
    .clock       (clock),
    .resetn      (resetn),
    .write       (write6),
    .digit       (digit6),
    .backspace   (backspace6),
    .clear       (clear6),
    .code_ack    (code_ack6),
    .out_keycode (out_keycode6),
    .digit_count (digit_count6),
    .code_valid  (code_valid6),
    .entry_active(entry_active6),
    .timeout     (timeout6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of strobes on the 4x4 instance, starting at a falling
  // edge; returns at the next falling edge with the strobes released.
  task automatic apply_stimulus(input logic w, input logic [3:0] d,
                                input logic b, input logic c, input logic a);
    write     = w;
    digit     = d;
    backspace = b;
    clear     = c;
    code_ack  = a;
    @(negedge clock);
    write     = 1'b0;
    digit     = 4'h0;
    backspace = 1'b0;
    clear     = 1'b0;
    code_ack  = 1'b0;
  endtask

  task automatic apply_stimulus6(input logic w, input logic [2:0] d,
                                 input logic b);
    write6     = w;
    digit6     = d;
    backspace6 = b;
    @(negedge clock);
    write6     = 1'b0;
    digit6     = 3'd0;
    backspace6 = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pulses;
    checks     = 0;
    passed     = 0;
    resetn     = 1'b0;
    write      = 1'b0;
    digit      = 4'h0;
    backspace  = 1'b0;
    clear      = 1'b0;
    code_ack   = 1'b0;
    write6     = 1'b0;
    digit6     = 3'd0;
    backspace6 = 1'b0;
    clear6     = 1'b0;
    code_ack6  = 1'b0;

    repeat (3) @(negedge clock);
    resetn = 1'b1;

    check_output("reset_keycode", 32'(out_keycode), 32'h0);
    check_output("reset_count", 32'(digit_count), 32'd0);
    check_output("reset_valid", 32'(code_valid), 32'd0);
    check_output("reset_active", 32'(entry_active), 32'd0);
    check_output("reset_timeout", 32'(timeout), 32'd0);

    // Basic entry 1,2,3,4 and acknowledge.
    key(4'h1);
    key(4'h2);
    key(4'h3);
    check_output("partial_keycode", 32'(out_keycode), 32'h0321);
    check_output("partial_count", 32'(digit_count), 32'd3);
    check_output("partial_active", 32'(entry_active), 32'd1);
    check_output("partial_valid", 32'(code_valid), 32'd0);
    key(4'h4);
    check_output("full_keycode", 32'(out_keycode), 32'h4321);
    check_output("full_count", 32'(digit_count), 32'd4);
    check_output("full_valid", 32'(code_valid), 32'd1);
    check_output("full_active", 32'(entry_active), 32'd0);
    idle_cycle();
    check_output("held_valid", 32'(code_valid), 32'd1);
    check_output("held_keycode", 32'(out_keycode), 32'h4321);
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_output("ack_keycode", 32'(out_keycode), 32'h0);
    check_output("ack_count", 32'(digit_count), 32'd0);
    check_output("ack_valid", 32'(code_valid), 32'd0);

    // Backspace in the middle of an entry.
    key(4'h5);
    key(4'h6);
    apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_output("bksp_count", 32'(digit_count), 32'd1);
    key(4'h7);
    check_output("bksp_keycode", 32'(out_keycode), 32'h0075);
    check_output("bksp_count2", 32'(digit_count), 32'd2);
    check_output("bksp_active", 32'(entry_active), 32'd1);
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_output("clear_count", 32'(digit_count), 32'd0);

    // A full code ignores further writes; ack beats a simultaneous write.
    key(4'h9);
    key(4'h8);
    key(4'h7);
    key(4'h6);
    key(4'hA);
    check_output("full_write_keycode", 32'(out_keycode), 32'h6789);
    check_output("full_write_valid", 32'(code_valid), 32'd1);
    check_output("full_write_count", 32'(digit_count), 32'd4);
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check_output("no_ack_keycode", 32'(out_keycode), 32'h6789);
    apply_stimulus(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
    check_output("ack_write_keycode", 32'(out_keycode), 32'h0);
    check_output("ack_write_count", 32'(digit_count), 32'd0);
    check_output("ack_write_valid", 32'(code_valid), 32'd0);

    // Ack outside FULL is ignored.
    key(4'h2);
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_output("stray_ack_keycode", 32'(out_keycode), 32'h0002);
    check_output("stray_ack_count", 32'(digit_count), 32'd1);
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Priority: clear over write, backspace over write.
    key(4'h1);
    key(4'h2);
    apply_stimulus(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
    check_output("clear_wins_count", 32'(digit_count), 32'd0);
    check_output("clear_wins_keycode", 32'(out_keycode), 32'h0);
    check_output("clear_wins_active", 32'(entry_active), 32'd0);
    apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check_output("bksp_empty_count", 32'(digit_count), 32'd0);
    key(4'h1);
    apply_stimulus(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    check_output("bksp_wins_count", 32'(digit_count), 32'd0);
    check_output("bksp_wins_keycode", 32'(out_keycode), 32'h0);

    // Reset mid-entry discards everything.
    key(4'h1);
    key(4'h2);
    key(4'h3);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check_output("midreset_keycode", 32'(out_keycode), 32'h0);
    check_output("midreset_count", 32'(digit_count), 32'd0);
    check_output("midreset_active", 32'(entry_active), 32'd0);
    check_output("midreset_valid", 32'(code_valid), 32'd0);

    // 6 digits of 3 bits.
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus6(1'b1, 3'(i), 1'b0);
    end
    check_output("six_keycode", 32'(out_keycode6), 32'(18'o654321));
    check_output("six_valid", 32'(code_valid6), 32'd1);
    check_output("six_count", 32'(digit_count6), 32'd6);
    apply_stimulus6(1'b0, 3'd0, 1'b1);
    check_output("six_bksp_count", 32'(digit_count6), 32'd5);
    check_output("six_bksp_valid", 32'(code_valid6), 32'd0);
    check_output("six_bksp_active", 32'(entry_active6), 32'd1);
    check_output("six_bksp_keycode", 32'(out_keycode6), 32'(18'o054321));

`ifdef KEYCODE_TIMEOUT_EN
    // Abandoned partial entry: timeout pulses 8 cycles after the strobe.
    key(4'h3);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (timeout) pulses++;
      if (i == 8) begin
        check_output("tmo_pulse", 32'(timeout), 32'd1);
        check_output("tmo_count", 32'(digit_count), 32'd0);
        check_output("tmo_active", 32'(entry_active), 32'd0);
      end
    end
    check_output("tmo_pulse_count", 32'(pulses), 32'd1);

    // A full code waiting for ack never times out.
    key(4'h1);
    key(4'h2);
    key(4'h3);
    key(4'h4);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (timeout) pulses++;
    end
    check_output("full_no_tmo", 32'(pulses), 32'd0);
    check_output("full_no_tmo_valid", 32'(code_valid), 32'd1);
    check_output("full_no_tmo_keycode", 32'(out_keycode), 32'h4321);
`else
    // Without the timer, a partial entry is kept indefinitely.
    key(4'h3);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (timeout) pulses++;
    end
    check_output("no_timer_pulses", 32'(pulses), 32'd0);
    check_output("no_timer_count", 32'(digit_count), 32'd1);
    check_output("no_timer_keycode", 32'(out_keycode), 32'h0003);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keycode_entry.md
Name: keycode_entry

Overview:
Parametrised keypad code-entry buffer for the home alarm. It collects NUM_DIGITS digits of DIGIT_W bits from single-cycle write strobes into a packed keycode, and supports backspace and clear. When the code is complete it presents the code with a valid/ack handshake. It sits between the keypad debouncer/edge detector and the alarm code comparator FSM.

Parameters:
NUM_DIGITS, 4, number of digits per code (>=2)
DIGIT_W, 4, bits per digit
TIMEOUT_CYC, 50000000, idle cycles before entry is abandoned (used only with KEYCODE_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
write  in  1  single-cycle strobe: digit is valid this cycle
digit  in  DIGIT_W  digit value sampled when write=1
backspace  in  1  single-cycle strobe: remove last digit
clear  in  1  single-cycle strobe: discard entire entry
code_ack  in  1  consumer has taken out_keycode
out_keycode  out  NUM_DIGITS*DIGIT_W  packed code; digit k (k-th entered, from 0) at [k*DIGIT_W +: DIGIT_W]
digit_count  out  $clog2(NUM_DIGITS+1)  digits currently held
code_valid  out  1  high while a complete code is presented
entry_active  out  1  high while 1..NUM_DIGITS-1 digits are held
timeout  out  1  one-cycle pulse when entry is abandoned on inactivity

Behaviour:
- Reset, synchronous active-low: state IDLE; out_keycode=0, digit_count=0, code_valid=0, entry_active=0, timeout=0. Reset mid-entry discards all digits.
- States: IDLE (count=0), ENTRY (0<count<NUM_DIGITS), FULL (count=NUM_DIGITS).
- Priority per cycle: clear > backspace > write. Only one action is taken per cycle.
- write in IDLE/ENTRY: slot[count] <= digit; count++. Registered: visible on out_keycode/digit_count the cycle after the strobe. When count becomes NUM_DIGITS, go to FULL and raise code_valid the same cycle the last digit appears.
- write in FULL: ignored. Buffer unchanged and no overwrite or wrap to slot 0. This replaces the old wrap-around behaviour.
- Every cycle write=1 counts as one digit. Level-held write enters repeated digits, so the caller must edge-detect.
- backspace with count>0 (including FULL): slot[count-1] <= 0; count--. FULL->ENTRY drops code_valid the next cycle. backspace with count=0 is a no-op.
- clear: all slots=0, count=0, go to IDLE, from any state.
- code_valid is a level signal, held stable with out_keycode constant until code_ack=1 while in FULL. On that edge, clear the buffer and go to IDLE. code_ack outside FULL is ignored.
- code_ack and write in the same FULL cycle: ack is taken and the write is dropped.
- entry_active = (state==ENTRY). code_valid = (state==FULL). Both are decoded from registered state, so there is no combinational path from inputs to outputs.
- Unused slots always read 0.

Optional Feature:
KEYCODE_TIMEOUT_EN
- Defined: a counter is reset on every accepted write or backspace and on entering ENTRY. It increments while in ENTRY. On reaching TIMEOUT_CYC-1 the buffer is cleared, the block goes to IDLE, and timeout pulses for 1 cycle. The counter is frozen in IDLE and FULL, so a FULL code waiting for ack never times out.
- Not defined: no counter is instantiated, timeout is tied to 0, and TIMEOUT_CYC is unused.

Decomposition:
- Package keycode_pkg: state enum (IDLE, ENTRY, FULL) with 2-bit encoding; default NUM_DIGITS/DIGIT_W constants shared with the comparator.
- Sub-module keycode_idle_timer (counter, clear/enable/expire), instantiated only under KEYCODE_TIMEOUT_EN.

Test Plan:
- Defaults; write 1,2,3,4 on separate cycles -> out_keycode=16'h4321, digit_count=4, code_valid=1 the cycle after the 4th strobe; code_ack -> next cycle out_keycode=0, count=0.
- Write 5,6; backspace; write 7 -> out_keycode=16'h0075, count=2, entry_active=1.
- Full code 9,8,7,6 held without ack; write A -> out_keycode stays 16'h6789 and code_valid stays 1.
- Write 1,2 then clear and write 3 in the same cycle -> count=0, out_keycode=0 (clear wins). Separately, resetn=0 after 3 digits -> all outputs 0 the next cycle.
- NUM_DIGITS=6, DIGIT_W=3: enter 1..6 -> out_keycode=18'o654321, code_valid=1; backspace in FULL -> count=5, code_valid=0, slot5=0.
- KEYCODE_TIMEOUT_EN with TIMEOUT_CYC=8: write 3 then idle -> timeout pulses once 8 cycles after the strobe, count=0. A full code left unacknowledged for 20 cycles produces no timeout.
